// File: rtl/exec_fill_scheduler.sv
// Fill-event scheduler feeding the inventory update port: FIFO-buffered fills, one registered
// update per cycle, per-stock hold-off while a quote snapshot is in flight, saturating positions.
module exec_fill_scheduler #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned NUM_STOCKS   = 4,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned MAX_POSITION = 1000
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic                          i_fill_valid,
   output logic                          o_fill_ready,
   input  logic [$clog2(NUM_STOCKS)-1:0] i_fill_stock_id,
   input  logic [DATA_WIDTH-1:0]         i_fill_quantity,
   input  logic                          i_fill_side,
   input  logic                          i_quote_busy,
   input  logic [$clog2(NUM_STOCKS)-1:0] i_quote_stock_id,
   output logic                          o_execute_order,
   output logic                          o_execute_order_side,
   output logic [DATA_WIDTH-1:0]         o_execute_order_quantity,
   output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
   output logic signed [DATA_WIDTH+1:0]  o_position [NUM_STOCKS],
   output logic [NUM_STOCKS-1:0]         o_limit_breach,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

   localparam int unsigned ID_W  = $clog2(NUM_STOCKS);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned POS_W = DATA_WIDTH + 2;

   localparam logic [POS_W-1:0]        POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
   localparam logic [POS_W-1:0]        POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
   localparam logic signed [POS_W:0]   LIM_HI  = (POS_W+1)'(MAX_POSITION);
   localparam logic signed [POS_W:0]   LIM_LO  = -LIM_HI;

   // Fill storage; not reset, since the pointers and count define what is valid.
   logic [ID_W-1:0]       r_mem_stock [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_mem_qty   [FIFO_DEPTH];
   logic                  r_mem_side  [FIFO_DEPTH];

   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [CNT_W-1:0]       r_count;
   logic [CNT_W-1:0]       w_count_next;

   logic                   r_exec;
   logic                   r_exec_side;
   logic [DATA_WIDTH-1:0]  r_exec_qty;
   logic [ID_W-1:0]        r_exec_stock;
   logic signed [POS_W-1:0] r_position [NUM_STOCKS];

   logic                   w_push;
   logic                   w_empty;
   logic                   w_stall;
   logic                   w_pop;
   logic                   w_issue;
   logic [ID_W-1:0]        w_head_stock;
   logic [DATA_WIDTH-1:0]  w_head_qty;
   logic                   w_head_side;

   logic [POS_W-1:0]       w_pos_cur;
   logic [POS_W:0]         w_cur_ext;
   logic [POS_W:0]         w_qty_ext;
   logic [POS_W:0]         w_sum;
   logic [POS_W-1:0]       w_pos_next;

   assign o_fill_ready = (r_count != CNT_W'(FIFO_DEPTH));
   assign w_push       = i_fill_valid & o_fill_ready;
   assign w_empty      = (r_count == '0);

   assign w_head_stock = r_mem_stock[r_rd_ptr];
   assign w_head_qty   = r_mem_qty[r_rd_ptr];
   assign w_head_side  = r_mem_side[r_rd_ptr];

   // Head-of-line blocking: a stalled head holds back everything behind it.
   assign w_stall = i_quote_busy & (i_quote_stock_id == w_head_stock);
   assign w_pop   = ~w_empty & ~w_stall;
   assign w_issue = w_pop & (w_head_qty != '0);

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + CNT_W'(1);
         2'b01:   w_count_next = r_count - CNT_W'(1);
         default: w_count_next = r_count;
      endcase
   end

   // One extra bit of headroom; disagreeing top bits mean the result left the POS_W range.
   always_comb begin
      w_pos_cur = r_position[w_head_stock];
      w_cur_ext = {w_pos_cur[POS_W-1], w_pos_cur};
      w_qty_ext = {3'b000, w_head_qty};
      w_sum     = w_head_side ? (w_cur_ext - w_qty_ext) : (w_cur_ext + w_qty_ext);
      if (w_sum[POS_W] != w_sum[POS_W-1]) begin
         w_pos_next = w_sum[POS_W] ? POS_MIN : POS_MAX;
      end else begin
         w_pos_next = w_sum[POS_W-1:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem_stock[r_wr_ptr] <= i_fill_stock_id;
         r_mem_qty[r_wr_ptr]   <= i_fill_quantity;
         r_mem_side[r_wr_ptr]  <= i_fill_side;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_exec       <= 1'b0;
         r_exec_side  <= 1'b0;
         r_exec_qty   <= '0;
         r_exec_stock <= '0;
         for (int i = 0; i < NUM_STOCKS; i++) begin
            r_position[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= w_count_next;
         r_exec  <= w_issue;
         if (w_issue) begin
            r_exec_side               <= w_head_side;
            r_exec_qty                <= w_head_qty;
            r_exec_stock              <= w_head_stock;
            r_position[w_head_stock]  <= w_pos_next;
         end
      end
   end

   for (genvar g = 0; g < NUM_STOCKS; g++) begin : g_breach
      logic signed [POS_W:0] w_pos_ext;
      assign w_pos_ext         = {r_position[g][POS_W-1], r_position[g]};
      assign o_limit_breach[g] = (w_pos_ext > LIM_HI) || (w_pos_ext < LIM_LO);
   end

   assign o_position               = r_position;
   assign o_execute_order          = r_exec;
   assign o_execute_order_side     = r_exec_side;
   assign o_execute_order_quantity = r_exec_qty;
   assign o_stock_id               = r_exec_stock;
   assign o_fifo_count             = r_count;

endmodule
